axil_decoder_1to2: RTL and testbench



---
 rtl/axil_decoder_1to2.sv | 259 +++++++++++++++++++++++++
 tb/tb_axil_decoder_1to2.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_decoder_1to2.sv
// AXI4-Lite 1-to-2 decoder between the core and memory (slave 0) / UART (slave 1).
// Unmapped accesses are completed locally with a default response and flagged on decode_err.
module axil_decoder_1to2 #(
  parameter logic [31:0] S0_BASE       = 32'h0000_0000,
  parameter logic [31:0] S0_MASK       = 32'hFFFF_0000,
  parameter logic [31:0] S1_BASE       = 32'h0200_0000,
  parameter logic [31:0] S1_MASK       = 32'hFFFF_FF00,
  parameter logic [31:0] DEFAULT_RDATA = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_awaddr,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  input  logic [31:0] s_axi_araddr,
  input  logic [2:0]  s_axi_arprot,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready,
  output logic [31:0] s_axi_rdata,
  output logic        m0_axi_awvalid,
  input  logic        m0_axi_awready,
  output logic [31:0] m0_axi_awaddr,
  output logic [2:0]  m0_axi_awprot,
  output logic        m0_axi_wvalid,
  input  logic        m0_axi_wready,
  output logic [31:0] m0_axi_wdata,
  output logic [3:0]  m0_axi_wstrb,
  input  logic        m0_axi_bvalid,
  output logic        m0_axi_bready,
  output logic        m0_axi_arvalid,
  input  logic        m0_axi_arready,
  output logic [31:0] m0_axi_araddr,
  output logic [2:0]  m0_axi_arprot,
  input  logic        m0_axi_rvalid,
  output logic        m0_axi_rready,
  input  logic [31:0] m0_axi_rdata,
  output logic        m1_axi_awvalid,
  input  logic        m1_axi_awready,
  output logic [31:0] m1_axi_awaddr,
  output logic [2:0]  m1_axi_awprot,
  output logic        m1_axi_wvalid,
  input  logic        m1_axi_wready,
  output logic [31:0] m1_axi_wdata,
  output logic [3:0]  m1_axi_wstrb,
  input  logic        m1_axi_bvalid,
  output logic        m1_axi_bready,
  output logic        m1_axi_arvalid,
  input  logic        m1_axi_arready,
  output logic [31:0] m1_axi_araddr,
  output logic [2:0]  m1_axi_arprot,
  input  logic        m1_axi_rvalid,
  output logic        m1_axi_rready,
  input  logic [31:0] m1_axi_rdata,
  output logic        decode_err,
  output logic [2:0]  w_state_dbg,
  output logic [2:0]  r_state_dbg
);

  // Handshake rule on every channel: a beat transfers on a rising edge where valid && ready;
  // a raised valid holds with a stable payload until that edge; ready may lead or follow valid.
  typedef enum logic [2:0] {W_IDLE, W_DATA, W_ISSUE, W_RESP, W_LOCAL} w_state_t;
  typedef enum logic [2:0] {R_IDLE, R_ISSUE, R_DATA, R_LOCAL} r_state_t;

  // Returns {mapped, select}; slave 1 wins an overlap.
  function automatic logic [1:0] decode(input logic [31:0] a);
    if ((a & S1_MASK) == S1_BASE)      return 2'b11;
    else if ((a & S0_MASK) == S0_BASE) return 2'b10;
    else                               return 2'b00;
  endfunction

  w_state_t    w_state;
  r_state_t    r_state;
  logic        aw_rdy, ar_rdy;
  logic [31:0] aw_addr_q, w_data_q, ar_addr_q;
  logic [2:0]  aw_prot_q, ar_prot_q;
  logic [3:0]  w_strb_q;
  logic        w_sel, w_map, r_sel;
  logic        aw_done, w_done;
  logic        w_err, r_err;

  logic [1:0]  w_dec, r_dec;
  logic        sel_awready, sel_wready, sel_bvalid, sel_arready, sel_rvalid;
  logic [31:0] sel_rdata;
  logic        issue_aw, issue_w, aw_fin, w_fin, w_resp, r_issue, r_data;

  assign w_dec       = decode(s_axi_awaddr);
  assign r_dec       = decode(s_axi_araddr);
  assign sel_awready = w_sel ? m1_axi_awready : m0_axi_awready;
  assign sel_wready  = w_sel ? m1_axi_wready  : m0_axi_wready;
  assign sel_bvalid  = w_sel ? m1_axi_bvalid  : m0_axi_bvalid;
  assign sel_arready = r_sel ? m1_axi_arready : m0_axi_arready;
  assign sel_rvalid  = r_sel ? m1_axi_rvalid  : m0_axi_rvalid;
  assign sel_rdata   = r_sel ? m1_axi_rdata   : m0_axi_rdata;

  assign issue_aw = (w_state == W_ISSUE) && !aw_done;
  assign issue_w  = (w_state == W_ISSUE) && !w_done;
  assign aw_fin   = aw_done || sel_awready;
  assign w_fin    = w_done || sel_wready;
  assign w_resp   = (w_state == W_RESP);
  assign r_issue  = (r_state == R_ISSUE);
  assign r_data   = (r_state == R_DATA);

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      aw_rdy    <= 1'b0;
      aw_addr_q <= '0;
      aw_prot_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      w_sel     <= 1'b0;
      w_map     <= 1'b0;
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      w_err     <= 1'b0;
    end else begin
      w_err <= 1'b0;
      case (w_state)
        W_IDLE: begin
          aw_rdy <= 1'b1;
          if (s_axi_awvalid && aw_rdy) begin
            aw_addr_q <= s_axi_awaddr;
            aw_prot_q <= s_axi_awprot;
            w_map     <= w_dec[1];
            w_sel     <= w_dec[0];
            aw_rdy    <= 1'b0;
            w_state   <= W_DATA;
          end
        end
        W_DATA: begin
          if (s_axi_wvalid) begin
            w_data_q <= s_axi_wdata;
            w_strb_q <= s_axi_wstrb;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
            if (w_map) begin
              w_state <= W_ISSUE;
            end else begin
              w_err   <= 1'b1;
              w_state <= W_LOCAL;
            end
          end
        end
        W_ISSUE: begin
          aw_done <= aw_fin;
          w_done  <= w_fin;
          if (aw_fin && w_fin) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (sel_bvalid && s_axi_bready) begin
            aw_rdy  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        W_LOCAL: begin
          if (s_axi_bready) begin
            aw_rdy  <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      ar_rdy    <= 1'b0;
      ar_addr_q <= '0;
      ar_prot_q <= '0;
      r_sel     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        R_IDLE: begin
          ar_rdy <= 1'b1;
          if (s_axi_arvalid && ar_rdy) begin
            ar_addr_q <= s_axi_araddr;
            ar_prot_q <= s_axi_arprot;
            r_sel     <= r_dec[0];
            ar_rdy    <= 1'b0;
            if (r_dec[1]) begin
              r_state <= R_ISSUE;
            end else begin
              r_err   <= 1'b1;
              r_state <= R_LOCAL;
            end
          end
        end
        R_ISSUE: if (sel_arready) r_state <= R_DATA;
        R_DATA: begin
          if (sel_rvalid && s_axi_rready) begin
            ar_rdy  <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        R_LOCAL: begin
          if (s_axi_rready) begin
            ar_rdy  <= 1'b1;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = aw_rdy;
  assign s_axi_wready  = (w_state == W_DATA);
  assign s_axi_bvalid  = (w_state == W_LOCAL) || (w_resp && sel_bvalid);
  assign s_axi_arready = ar_rdy;
  assign s_axi_rvalid  = (r_state == R_LOCAL) || (r_data && sel_rvalid);
  assign s_axi_rdata   = (r_state == R_LOCAL) ? DEFAULT_RDATA : sel_rdata;

  // The idle slave sees every valid/ready low; its payload wires simply mirror the registers.
  assign m0_axi_awvalid = issue_aw && !w_sel;
  assign m1_axi_awvalid = issue_aw &&  w_sel;
  assign m0_axi_wvalid  = issue_w  && !w_sel;
  assign m1_axi_wvalid  = issue_w  &&  w_sel;
  assign m0_axi_bready  = w_resp && !w_sel && s_axi_bready;
  assign m1_axi_bready  = w_resp &&  w_sel && s_axi_bready;
  assign m0_axi_arvalid = r_issue && !r_sel;
  assign m1_axi_arvalid = r_issue &&  r_sel;
  assign m0_axi_rready  = r_data && !r_sel && s_axi_rready;
  assign m1_axi_rready  = r_data &&  r_sel && s_axi_rready;

  assign m0_axi_awaddr = aw_addr_q;
  assign m1_axi_awaddr = aw_addr_q;
  assign m0_axi_awprot = aw_prot_q;
  assign m1_axi_awprot = aw_prot_q;
  assign m0_axi_wdata  = w_data_q;
  assign m1_axi_wdata  = w_data_q;
  assign m0_axi_wstrb  = w_strb_q;
  assign m1_axi_wstrb  = w_strb_q;
  assign m0_axi_araddr = ar_addr_q;
  assign m1_axi_araddr = ar_addr_q;
  assign m0_axi_arprot = ar_prot_q;
  assign m1_axi_arprot = ar_prot_q;

  assign decode_err  = w_err || r_err;
  assign w_state_dbg = w_state;
  assign r_state_dbg = r_state;

endmodule

// File: tb/tb_axil_decoder_1to2.sv
// Directed bench for axil_decoder_1to2: behavioural memory and UART slaves, cycle-exact
// latency checks, unmapped accesses, a stalled slave, concurrent traffic and mid-read reset.
module tb_axil_decoder_1to2;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [2:0]  s_axi_awprot, s_axi_arprot;
  logic [3:0]  s_axi_wstrb;
  logic        m0_axi_awvalid, m0_axi_awready, m0_axi_wvalid, m0_axi_wready, m0_axi_bvalid, m0_axi_bready;
  logic        m0_axi_arvalid, m0_axi_arready, m0_axi_rvalid, m0_axi_rready;
  logic [31:0] m0_axi_awaddr, m0_axi_wdata, m0_axi_araddr, m0_axi_rdata;
  logic [2:0]  m0_axi_awprot, m0_axi_arprot;
  logic [3:0]  m0_axi_wstrb;
  logic        m1_axi_awvalid, m1_axi_awready, m1_axi_wvalid, m1_axi_wready, m1_axi_bvalid, m1_axi_bready;
  logic        m1_axi_arvalid, m1_axi_arready, m1_axi_rvalid, m1_axi_rready;
  logic [31:0] m1_axi_awaddr, m1_axi_wdata, m1_axi_araddr, m1_axi_rdata;
  logic [2:0]  m1_axi_awprot, m1_axi_arprot;
  logic [3:0]  m1_axi_wstrb;
  logic        decode_err;
  logic [2:0]  w_state_dbg, r_state_dbg;

  int total = 0;
  int bad = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  axil_decoder_1to2 dut (
    .clk(clk), .reset(reset),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_awprot(s_axi_awprot), .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready), .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot), .s_axi_rvalid(s_axi_rvalid),
    .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .m0_axi_awvalid(m0_axi_awvalid), .m0_axi_awready(m0_axi_awready), .m0_axi_awaddr(m0_axi_awaddr),
    .m0_axi_awprot(m0_axi_awprot), .m0_axi_wvalid(m0_axi_wvalid), .m0_axi_wready(m0_axi_wready),
    .m0_axi_wdata(m0_axi_wdata), .m0_axi_wstrb(m0_axi_wstrb), .m0_axi_bvalid(m0_axi_bvalid),
    .m0_axi_bready(m0_axi_bready), .m0_axi_arvalid(m0_axi_arvalid), .m0_axi_arready(m0_axi_arready),
    .m0_axi_araddr(m0_axi_araddr), .m0_axi_arprot(m0_axi_arprot), .m0_axi_rvalid(m0_axi_rvalid),
    .m0_axi_rready(m0_axi_rready), .m0_axi_rdata(m0_axi_rdata),
    .m1_axi_awvalid(m1_axi_awvalid), .m1_axi_awready(m1_axi_awready), .m1_axi_awaddr(m1_axi_awaddr),
    .m1_axi_awprot(m1_axi_awprot), .m1_axi_wvalid(m1_axi_wvalid), .m1_axi_wready(m1_axi_wready),
    .m1_axi_wdata(m1_axi_wdata), .m1_axi_wstrb(m1_axi_wstrb), .m1_axi_bvalid(m1_axi_bvalid),
    .m1_axi_bready(m1_axi_bready), .m1_axi_arvalid(m1_axi_arvalid), .m1_axi_arready(m1_axi_arready),
    .m1_axi_araddr(m1_axi_araddr), .m1_axi_arprot(m1_axi_arprot), .m1_axi_rvalid(m1_axi_rvalid),
    .m1_axi_rready(m1_axi_rready), .m1_axi_rdata(m1_axi_rdata),
    .decode_err(decode_err), .w_state_dbg(w_state_dbg), .r_state_dbg(r_state_dbg)
  );

  // ---------------- slave 0: memory, optional AW stall ----------------
  logic [31:0] mem0 [0:63];
  logic        s0_aw_got, s0_w_got;
  logic [31:0] s0_awa, s0_wd;
  int          s0_aw_cnt;
  int          s0_aw_stall = 0;
  int          s0_wr_cnt = 0;

  assign m0_axi_awready = !s0_aw_got && (s0_aw_cnt >= s0_aw_stall);
  assign m0_axi_wready  = !s0_w_got;
  assign m0_axi_arready = !m0_axi_rvalid;

  always @(posedge clk) begin
    if (reset) begin
      s0_aw_got <= 1'b0; s0_w_got <= 1'b0; s0_aw_cnt <= 0;
      m0_axi_bvalid <= 1'b0; m0_axi_rvalid <= 1'b0; m0_axi_rdata <= '0;
      mem0[4] <= 32'h1234_5678;
    end else begin
      if (m0_axi_awvalid && m0_axi_awready) begin
        s0_aw_got <= 1'b1; s0_awa <= m0_axi_awaddr; s0_aw_cnt <= 0;
      end else if (m0_axi_awvalid) s0_aw_cnt <= s0_aw_cnt + 1;
      if (m0_axi_wvalid && m0_axi_wready) begin s0_w_got <= 1'b1; s0_wd <= m0_axi_wdata; end
      if (s0_aw_got && s0_w_got && !m0_axi_bvalid) begin
        mem0[s0_awa[7:2]] <= s0_wd; s0_wr_cnt <= s0_wr_cnt + 1; m0_axi_bvalid <= 1'b1;
      end
      if (m0_axi_bvalid && m0_axi_bready) begin
        m0_axi_bvalid <= 1'b0; s0_aw_got <= 1'b0; s0_w_got <= 1'b0;
      end
      if (m0_axi_arvalid && m0_axi_arready) begin
        m0_axi_rvalid <= 1'b1; m0_axi_rdata <= mem0[m0_axi_araddr[7:2]];
      end else if (m0_axi_rvalid && m0_axi_rready) m0_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- slave 1: UART register file ----------------
  logic [31:0] mem1 [0:63];
  logic        s1_aw_got, s1_w_got;
  logic [31:0] s1_awa, s1_wd;
  logic [3:0]  s1_ws;

  assign m1_axi_awready = !s1_aw_got;
  assign m1_axi_wready  = !s1_w_got;
  assign m1_axi_arready = !m1_axi_rvalid;

  always @(posedge clk) begin
    if (reset) begin
      s1_aw_got <= 1'b0; s1_w_got <= 1'b0;
      m1_axi_bvalid <= 1'b0; m1_axi_rvalid <= 1'b0; m1_axi_rdata <= '0;
    end else begin
      if (m1_axi_awvalid && m1_axi_awready) begin s1_aw_got <= 1'b1; s1_awa <= m1_axi_awaddr; end
      if (m1_axi_wvalid && m1_axi_wready) begin
        s1_w_got <= 1'b1; s1_wd <= m1_axi_wdata; s1_ws <= m1_axi_wstrb;
      end
      if (s1_aw_got && s1_w_got && !m1_axi_bvalid) begin
        mem1[s1_awa[7:2]] <= s1_wd; m1_axi_bvalid <= 1'b1;
      end
      if (m1_axi_bvalid && m1_axi_bready) begin
        m1_axi_bvalid <= 1'b0; s1_aw_got <= 1'b0; s1_w_got <= 1'b0;
      end
      if (m1_axi_arvalid && m1_axi_arready) begin
        m1_axi_rvalid <= 1'b1; m1_axi_rdata <= mem1[m1_axi_araddr[7:2]];
      end else if (m1_axi_rvalid && m1_axi_rready) m1_axi_rvalid <= 1'b0;
    end
  end

  // ---------------- activity counters ----------------
  int m0_ar_cyc = 0, m1_ar_cyc = 0, m0_aw_cyc = 0, m1_aw_cyc = 0, err_cyc = 0, b_hs = 0;
  always @(posedge clk) begin
    if (m0_axi_arvalid) m0_ar_cyc <= m0_ar_cyc + 1;
    if (m1_axi_arvalid) m1_ar_cyc <= m1_ar_cyc + 1;
    if (m0_axi_awvalid || m0_axi_wvalid) m0_aw_cyc <= m0_aw_cyc + 1;
    if (m1_axi_awvalid || m1_axi_wvalid) m1_aw_cyc <= m1_aw_cyc + 1;
    if (decode_err) err_cyc <= err_cyc + 1;
    if (s_axi_bvalid && s_axi_bready) b_hs <= b_hs + 1;
  end

  // ---------------- checks ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks (entered just after a falling edge) ----------------
  task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
    int n;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1; #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
    chk1({tag, "_arready"}, s_axi_arready, 1'b1);
    @(negedge clk); s_axi_arvalid = 1'b0; #1;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); #1; n++; end
    chk1({tag, "_rvalid"}, s_axi_rvalid, 1'b1);
    chk({tag, "_rdata"}, s_axi_rdata, exp);
    @(negedge clk); #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input string tag);
    int n;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1; #1;
    n = 0;
    while (!s_axi_awready && n < 20) begin @(negedge clk); #1; n++; end
    chk1({tag, "_awready"}, s_axi_awready, 1'b1);
    @(negedge clk); s_axi_awvalid = 1'b0; s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1; #1;
    n = 0;
    while (!s_axi_wready && n < 20) begin @(negedge clk); #1; n++; end
    chk1({tag, "_wready"}, s_axi_wready, 1'b1);
    @(negedge clk); s_axi_wvalid = 1'b0; #1;
    n = 0;
    while (!s_axi_bvalid && n < 40) begin @(negedge clk); #1; n++; end
    chk1({tag, "_bvalid"}, s_axi_bvalid, 1'b1);
    @(negedge clk); #1;
  endtask

  int snap0, snap1, snap2, snap3;

  initial begin
    reset = 1'b1;
    s_axi_awvalid = 1'b0; s_axi_awaddr = '0; s_axi_awprot = '0;
    s_axi_wvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0; s_axi_araddr = '0; s_axi_arprot = '0; s_axi_rready = 1'b0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk1("rst_awready", s_axi_awready, 1'b0);
    chk1("rst_arready", s_axi_arready, 1'b0);
    chk1("rst_bvalid", s_axi_bvalid, 1'b0);
    chk1("rst_rvalid", s_axi_rvalid, 1'b0);
    chk1("rst_decode_err", decode_err, 1'b0);
    chk1("rst_m_valids", m0_axi_awvalid | m0_axi_wvalid | m0_axi_arvalid |
                         m1_axi_awvalid | m1_axi_wvalid | m1_axi_arvalid, 1'b0);
    chk("rst_w_state", {29'd0, w_state_dbg}, 32'd0);
    chk("rst_m0_awaddr", m0_axi_awaddr, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk1("post_rst_awready", s_axi_awready, 1'b1);
    chk1("post_rst_arready", s_axi_arready, 1'b1);

    // mapped read from memory, cycle by cycle
    snap1 = m1_ar_cyc;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0010; s_axi_rready = 1'b1; #1;
    @(negedge clk); s_axi_arvalid = 1'b0; #1;
    chk1("rd0_m0_arvalid", m0_axi_arvalid, 1'b1);
    chk("rd0_m0_araddr", m0_axi_araddr, 32'h0000_0010);
    chk1("rd0_m1_arvalid", m1_axi_arvalid, 1'b0);
    chk1("rd0_rvalid_early", s_axi_rvalid, 1'b0);
    @(negedge clk); #1;
    chk1("rd0_rvalid", s_axi_rvalid, 1'b1);
    chk("rd0_rdata", s_axi_rdata, 32'h1234_5678);
    @(negedge clk); #1;
    chk1("rd0_rvalid_done", s_axi_rvalid, 1'b0);
    chk1("rd0_arready_back", s_axi_arready, 1'b1);
    chk("rd0_m1_ar_cycles", m1_ar_cyc - snap1, 32'd0);

    // write to UART
    snap0 = b_hs; snap1 = s0_wr_cnt; snap2 = m0_aw_cyc;
    do_write(32'h0200_0008, 32'h0000_0041, 4'b0001, "wr1");
    chk("wr1_m1_awaddr", s1_awa, 32'h0200_0008);
    chk("wr1_m1_wdata", s1_wd, 32'h0000_0041);
    chk("wr1_m1_wstrb", {28'd0, s1_ws}, 32'd1);
    chk("wr1_b_handshakes", b_hs - snap0, 32'd1);
    chk("wr1_mem_writes", s0_wr_cnt - snap1, 32'd0);
    chk("wr1_m0_activity", m0_aw_cyc - snap2, 32'd0);
    do_read(32'h0200_0008, 32'h0000_0041, "rd1");

    // unmapped read
    snap0 = err_cyc; snap1 = m0_ar_cyc; snap2 = m1_ar_cyc;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h1000_0000; s_axi_rready = 1'b1; #1;
    chk1("urd_arready", s_axi_arready, 1'b1);
    @(negedge clk); s_axi_arvalid = 1'b0; #1;
    chk1("urd_rvalid", s_axi_rvalid, 1'b1);
    chk("urd_rdata", s_axi_rdata, 32'hDEAD_BEEF);
    chk1("urd_decode_err", decode_err, 1'b1);
    @(negedge clk); #1;
    chk1("urd_rvalid_done", s_axi_rvalid, 1'b0);
    chk1("urd_decode_err_low", decode_err, 1'b0);
    chk("urd_err_pulses", err_cyc - snap0, 32'd1);
    chk("urd_slave_ar", (m0_ar_cyc - snap1) + (m1_ar_cyc - snap2), 32'd0);

    // unmapped write
    snap0 = m0_aw_cyc; snap1 = m1_aw_cyc;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h3000_0000; s_axi_bready = 1'b1; #1;
    chk1("uwr_awready", s_axi_awready, 1'b1);
    @(negedge clk); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wdata = 32'h99; s_axi_wstrb = 4'hF; #1;
    chk1("uwr_wready", s_axi_wready, 1'b1);
    chk1("uwr_decode_err_early", decode_err, 1'b0);
    @(negedge clk); s_axi_wvalid = 1'b0; #1;
    chk1("uwr_bvalid", s_axi_bvalid, 1'b1);
    chk1("uwr_decode_err", decode_err, 1'b1);
    @(negedge clk); #1;
    chk1("uwr_bvalid_done", s_axi_bvalid, 1'b0);
    chk("uwr_slave_aw", (m0_aw_cyc - snap0) + (m1_aw_cyc - snap1), 32'd0);

    // memory slave stalls AW for three cycles, takes W at once
    s0_aw_stall = 3;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0000_0020; #1;
    chk1("stl_awready", s_axi_awready, 1'b1);
    @(negedge clk); s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b1; s_axi_wdata = 32'hCAFE_0001; #1;
    @(negedge clk); s_axi_wvalid = 1'b0; #1;
    chk1("stl_c2_awvalid", m0_axi_awvalid, 1'b1);
    chk1("stl_c2_wvalid", m0_axi_wvalid, 1'b1);
    chk("stl_c2_awaddr", m0_axi_awaddr, 32'h0000_0020);
    chk("stl_c2_wdata", m0_axi_wdata, 32'hCAFE_0001);
    @(negedge clk); #1;
    chk1("stl_c3_wvalid", m0_axi_wvalid, 1'b0);
    chk1("stl_c3_awvalid", m0_axi_awvalid, 1'b1);
    chk1("stl_c3_bvalid", s_axi_bvalid, 1'b0);
    @(negedge clk); #1;
    chk1("stl_c4_awvalid", m0_axi_awvalid, 1'b1);
    @(negedge clk); #1;
    chk1("stl_c5_awvalid", m0_axi_awvalid, 1'b1);
    chk1("stl_c5_awready", m0_axi_awready, 1'b1);
    @(negedge clk); #1;
    chk1("stl_c6_awvalid", m0_axi_awvalid, 1'b0);
    chk1("stl_c6_bvalid", s_axi_bvalid, 1'b0);
    @(negedge clk); #1;
    chk1("stl_c7_bvalid", s_axi_bvalid, 1'b1);
    @(negedge clk); #1;
    chk1("stl_c8_bvalid", s_axi_bvalid, 1'b0);
    s0_aw_stall = 0;
    do_read(32'h0000_0020, 32'hCAFE_0001, "stl_rd");

    // concurrent memory read and UART write
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0010;
    s_axi_awvalid = 1'b1; s_axi_awaddr = 32'h0200_0004; #1;
    chk1("cc_ready_both", s_axi_arready & s_axi_awready, 1'b1);
    @(negedge clk); s_axi_arvalid = 1'b0; s_axi_awvalid = 1'b0;
    s_axi_wvalid = 1'b1; s_axi_wdata = 32'h55; s_axi_wstrb = 4'b0001; #1;
    chk1("cc_m0_arvalid", m0_axi_arvalid, 1'b1);
    chk1("cc_m1_arvalid", m1_axi_arvalid, 1'b0);
    @(negedge clk); s_axi_wvalid = 1'b0; #1;
    chk1("cc_rvalid", s_axi_rvalid, 1'b1);
    chk("cc_rdata", s_axi_rdata, 32'h1234_5678);
    chk1("cc_bvalid_early", s_axi_bvalid, 1'b0);
    chk1("cc_m1_awvalid", m1_axi_awvalid, 1'b1);
    chk1("cc_m0_awvalid", m0_axi_awvalid, 1'b0);
    @(negedge clk); #1;
    chk1("cc_rvalid_done", s_axi_rvalid, 1'b0);
    @(negedge clk); #1;
    chk1("cc_bvalid", s_axi_bvalid, 1'b1);
    chk1("cc_rvalid_quiet", s_axi_rvalid, 1'b0);
    chk("cc_m1_wdata", s1_wd, 32'h55);
    chk("cc_m1_awaddr", s1_awa, 32'h0200_0004);
    @(negedge clk); #1;
    chk1("cc_bvalid_done", s_axi_bvalid, 1'b0);

    // reset while the read response is stalled by the core
    s_axi_rready = 1'b0;
    s_axi_arvalid = 1'b1; s_axi_araddr = 32'h0000_0010; #1;
    @(negedge clk); s_axi_arvalid = 1'b0; #1;
    @(negedge clk); #1;
    chk1("rr_rvalid", s_axi_rvalid, 1'b1);
    @(negedge clk); #1;
    chk1("rr_rvalid_held", s_axi_rvalid, 1'b1);
    reset = 1'b1;
    @(negedge clk); #1;
    chk1("rr_rvalid_cleared", s_axi_rvalid, 1'b0);
    chk1("rr_arready_in_reset", s_axi_arready, 1'b0);
    chk("rr_r_state", {29'd0, r_state_dbg}, 32'd0);
    reset = 1'b0;
    @(negedge clk); #1;
    chk1("rr_arready_after", s_axi_arready, 1'b1);
    do_read(32'h0000_0010, 32'h1234_5678, "rr_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
